// File: rtl/shift_seq_ctrl.sv
// Shift sequencer: selects a shift amount, loads the shifter, then issues one
// single-bit shift command per cycle until the latched amount is exhausted.
module shift_seq_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] shift_kind,
  input  logic [1:0] amt_src,
  input  logic [4:0] amt_in,
  output logic [2:0] amt_sel,
  output logic [2:0] shift_op,
  output logic       busy,
  output logic       done,
  output logic [4:0] count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_LOAD   = 3'd2,
    S_SHIFT  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SLL  = 3'b010;
  localparam logic [2:0] OP_SRL  = 3'b011;
  localparam logic [2:0] OP_SRA  = 3'b100;

  state_t     state_q, state_d;
  logic [1:0] kind_q, kind_d;
  logic [2:0] amt_sel_q, amt_sel_d;
  logic [4:0] count_q, count_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      kind_q    <= 2'b00;
      amt_sel_q <= 3'b000;
      count_q   <= 5'd0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      amt_sel_q <= amt_sel_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    amt_sel_d = amt_sel_q;
    count_d   = count_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          kind_d  = shift_kind;
          state_d = S_SELECT;
          case (amt_src)
            2'b00:   amt_sel_d = 3'b000;
            2'b01:   amt_sel_d = 3'b010;
            2'b10:   amt_sel_d = 3'b011;
            default: amt_sel_d = 3'b001;
          endcase
        end
      end
      S_SELECT: begin
        // The amount mux output is only trusted on the edge leaving SELECT.
        count_d = amt_in;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        if (count_q == 5'd0 || kind_q == 2'b11) state_d = S_DONE;
        else                                    state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (count_q <= 5'd1) begin
          count_d = 5'd0;
          state_d = S_DONE;
        end else begin
          count_d = count_q - 5'd1;
        end
      end
      S_DONE: begin
        amt_sel_d = 3'b000;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore decode: depends only on state and the latched kind.
  always_comb begin
    shift_op = OP_NOP;
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_DONE);
    case (state_q)
      S_LOAD: shift_op = OP_LOAD;
      S_SHIFT: begin
        case (kind_q)
          2'b00:   shift_op = OP_SLL;
          2'b01:   shift_op = OP_SRL;
          2'b10:   shift_op = OP_SRA;
          default: shift_op = OP_NOP;
        endcase
      end
      default: shift_op = OP_NOP;
    endcase
  end

  assign amt_sel = amt_sel_q;
  assign count   = count_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: directed sequences push a per-cycle expected output
// trace into a queue; a negedge monitor pops and compares it.
module tb_shift_seq_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic [1:0] shift_kind;
  logic [1:0] amt_src;
  logic [4:0] amt_in;
  logic [2:0] amt_sel;
  logic [2:0] shift_op;
  logic       busy;
  logic       done;
  logic [4:0] count;

  // Packed observation: {amt_sel, shift_op, busy, done, count}
  localparam int W = 13;
  logic [W-1:0] exp_q[$];

  int checks;
  int errors;
  logic [4:0] prev_cnt;

  shift_seq_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .shift_kind (shift_kind),
    .amt_src    (amt_src),
    .amt_in     (amt_in),
    .amt_sel    (amt_sel),
    .shift_op   (shift_op),
    .busy       (busy),
    .done       (done),
    .count      (count)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] pack(input logic [2:0] sel, input logic [2:0] op,
                                        input logic b, input logic d, input logic [4:0] c);
    return {sel, op, b, d, c};
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [W-1:0] a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = pack(amt_sel, shift_op, busy, done, count);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle_trace t=%0t got sel=%b op=%b busy=%b done=%b cnt=%0d expected sel=%b op=%b busy=%b done=%b cnt=%0d",
                 $time, a[12:10], a[9:7], a[6], a[5], a[4:0],
                 e[12:10], e[9:7], e[6], e[5], e[4:0]);
      end
    end
  end

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({amt_sel, shift_op, busy, done, count} !== '0) begin
      errors++;
      $display("FAIL %s got sel=%b op=%b busy=%b done=%b cnt=%0d expected all zero",
               name, amt_sel, shift_op, busy, done, count);
    end
  endtask

  task automatic wait_drain();
    int budget;
    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Expected outputs for cycle c of a sequence started at edge 0 (hand-supplied
  // sel and shift code per vector).
  function automatic logic [W-1:0] exp_cycle(input int c, input logic [1:0] kind,
                                             input logic [4:0] amt, input logic [2:0] sel,
                                             input logic [2:0] code, input logic [4:0] pc);
    int shifts;
    int done_c;
    logic [4:0] fin;
    shifts = (kind == 2'b11) ? 0 : int'(amt);
    done_c = shifts + 3;
    fin    = (kind == 2'b11) ? amt : 5'd0;
    if (c == 0)           return pack(3'b000, 3'b000, 1'b0, 1'b0, pc);
    else if (c == 1)      return pack(sel, 3'b000, 1'b1, 1'b0, pc);
    else if (c == 2)      return pack(sel, 3'b001, 1'b1, 1'b0, amt);
    else if (c < done_c)  return pack(sel, code, 1'b1, 1'b0, 5'(int'(amt) - (c - 3)));
    else if (c == done_c) return pack(sel, 3'b000, 1'b1, 1'b1, fin);
    else                  return pack(3'b000, 3'b000, 1'b0, 1'b0, fin);
  endfunction

  // Driver: one sequence; rst_c > 0 asserts reset during that cycle.
  task automatic run_seq(input logic [1:0] kind, input logic [1:0] src, input logic [4:0] amt,
                         input logic [2:0] sel, input logic [2:0] code,
                         input logic hold_start, input int rst_c);
    int last;
    last = ((kind == 2'b11) ? 0 : int'(amt)) + 4;
    @(posedge clk); #1;
    start = 1'b1; shift_kind = kind; amt_src = src; amt_in = amt;
    exp_q.push_back(exp_cycle(0, kind, amt, sel, code, prev_cnt));
    for (int c = 1; c <= last; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        start = hold_start; shift_kind = ~kind; amt_src = ~src;
      end
      if (c == 2) amt_in = ~amt;
      if (c == last) start = 1'b0;
      if (c == rst_c) begin
        #1 reset = 1'b1;
        #1 check_reset_outputs("reset_mid_seq");
        exp_q.push_back(pack(3'b000, 3'b000, 1'b0, 1'b0, 5'd0));
        start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.push_back(pack(3'b000, 3'b000, 1'b0, 1'b0, 5'd0));
        @(posedge clk); #1;
        exp_q.push_back(pack(3'b000, 3'b000, 1'b0, 1'b0, 5'd0));
        prev_cnt = 5'd0;
        break;
      end
      exp_q.push_back(exp_cycle(c, kind, amt, sel, code, prev_cnt));
      if (c == last) prev_cnt = exp_cycle(c, kind, amt, sel, code, prev_cnt) & 13'h1f;
    end
    wait_drain();
  endtask

  initial begin
    checks = 0; errors = 0; prev_cnt = 5'd0;
    reset = 1'b1; start = 1'b0; shift_kind = 2'b00; amt_src = 2'b00; amt_in = 5'd0;
    #2 check_reset_outputs("reset_initial");
    @(posedge clk); #1 reset = 1'b0;

    run_seq(2'b00, 2'b00, 5'd5,  3'b000, 3'b010, 1'b0, 0);
    run_seq(2'b10, 2'b01, 5'd0,  3'b010, 3'b100, 1'b0, 0);
    run_seq(2'b01, 2'b10, 5'd16, 3'b011, 3'b011, 1'b1, 0);
    run_seq(2'b00, 2'b00, 5'd31, 3'b000, 3'b010, 1'b0, 10);
    run_seq(2'b00, 2'b00, 5'd31, 3'b000, 3'b010, 1'b0, 0);
    run_seq(2'b11, 2'b11, 5'd7,  3'b001, 3'b000, 1'b0, 0);
    run_seq(2'b10, 2'b01, 5'd3,  3'b010, 3'b100, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
